// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the execute unit.
// Op codes, FSM states and multiply/divide signedness tables.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'b00000,
        OP_SUB    = 5'b00001,
        OP_SLT    = 5'b00010,
        OP_SLTU   = 5'b00011,
        OP_XOR    = 5'b00100,
        OP_AND    = 5'b00101,
        OP_OR     = 5'b00110,
        OP_SLL    = 5'b00111,
        OP_SRL    = 5'b01000,
        OP_SRA    = 5'b01001,
        OP_PASSB  = 5'b01010,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Wide enough for any supported XLEN; sliced at the use site.
    localparam logic [63:0] DIV0_QUOT = '1;

    // Indexed by op[2:0] of an M op: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU.
    localparam logic [7:0] A_SIGNED = 8'b0101_0111;
    localparam logic [7:0] B_SIGNED = 8'b0101_0011;

    function automatic logic is_mdu_op(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter: one-bit-per-cycle multiply/divide datapath.
// Shift-add multiply or restoring divide over unsigned magnitudes.
module alu_mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            step_i,
    input  logic            div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] acc, sreg, opb;
    logic [XLEN-1:0] acc_n, sreg_n;
    logic [XLEN:0]   sum, trial, diff;
    logic [CW-1:0]   cnt;
    logic            div_q;

    // Next accumulator/shift values for a single iteration.
    always_comb begin
        sum   = {1'b0, acc} + (sreg[0] ? {1'b0, opb} : '0);
        trial = {acc, sreg[XLEN-1]};
        diff  = trial - {1'b0, opb};
        acc_n  = acc;
        sreg_n = sreg;
        if (div_q) begin
            if (!diff[XLEN]) begin
                acc_n  = diff[XLEN-1:0];
                sreg_n = {sreg[XLEN-2:0], 1'b1};
            end else begin
                acc_n  = trial[XLEN-1:0];
                sreg_n = {sreg[XLEN-2:0], 1'b0};
            end
        end else begin
            {acc_n, sreg_n} = {sum, sreg[XLEN-1:1]};
        end
    end

    // Load operands on start, then iterate while stepping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc   <= '0;
            sreg  <= '0;
            opb   <= '0;
            cnt   <= '0;
            div_q <= 1'b0;
        end else if (start_i) begin
            acc   <= '0;
            sreg  <= a_i;
            opb   <= b_i;
            cnt   <= CW'(XLEN - 1);
            div_q <= div_i;
        end else if (step_i) begin
            acc  <= acc_n;
            sreg <= sreg_n;
            cnt  <= cnt - 1'b1;
        end
    end

    // Final values are presented during the last step cycle.
    assign done_o = (cnt == '0);
    assign hi_o   = acc_n;
    assign lo_o   = sreg_n;

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: execute stage with single-cycle ALU and iterative M unit.
// Valid/ready handshake on both sides; flush aborts any op in flight.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [4:0]      alu_op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] alu_result_o
);

    localparam int SW = $clog2(XLEN);

    state_e          state, state_n;
    alu_op_e         op;
    logic            accept, is_m, done;
    logic            sa, sb;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] base_res, mdu_res, res_q;
    logic [XLEN-1:0] hi, lo, quo_s, rem_s;
    logic [2*XLEN-1:0] prod_s;
    logic [SW-1:0]   shamt;
    logic [2:0]      op_q;
    logic            neg_q, negr_q, bz_q;

    assign op      = alu_op_e'(alu_op_i);
    assign is_m    = is_mdu_op(alu_op_i);
    assign ready_o = (state == S_IDLE);
    assign valid_o = (state == S_DONE);
    assign accept  = valid_i && ready_o && !flush_i;
    assign shamt   = rs2_data_i[SW-1:0];

    assign sa    = A_SIGNED[alu_op_i[2:0]] & rs1_data_i[XLEN-1];
    assign sb    = B_SIGNED[alu_op_i[2:0]] & rs2_data_i[XLEN-1];
    assign a_mag = sa ? -rs1_data_i : rs1_data_i;
    assign b_mag = sb ? -rs2_data_i : rs2_data_i;

    // Single-cycle base ALU on the live operands.
    always_comb begin
        base_res = '0;
        unique case (op)
            OP_ADD:   base_res = rs1_data_i + rs2_data_i;
            OP_SUB:   base_res = rs1_data_i - rs2_data_i;
            OP_SLT:   base_res = {{(XLEN-1){1'b0}},
                                  $signed(rs1_data_i) < $signed(rs2_data_i)};
            OP_SLTU:  base_res = {{(XLEN-1){1'b0}}, rs1_data_i < rs2_data_i};
            OP_XOR:   base_res = rs1_data_i ^ rs2_data_i;
            OP_AND:   base_res = rs1_data_i & rs2_data_i;
            OP_OR:    base_res = rs1_data_i | rs2_data_i;
            OP_SLL:   base_res = rs1_data_i << shamt;
            OP_SRL:   base_res = rs1_data_i >> shamt;
            OP_SRA:   base_res = $signed(rs1_data_i) >>> shamt;
            OP_PASSB: base_res = rs2_data_i;
            default:  base_res = '0;
        endcase
    end

    alu_mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (accept && is_m),
        .step_i  (state == S_BUSY),
        .div_i   (alu_op_i[2]),
        .a_i     (a_mag),
        .b_i     (b_mag),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    // Sign correction of the magnitude result and half/op selection.
    always_comb begin
        prod_s  = neg_q ? -{hi, lo} : {hi, lo};
        quo_s   = bz_q ? DIV0_QUOT[XLEN-1:0] : (neg_q ? -lo : lo);
        rem_s   = negr_q ? -hi : hi;
        mdu_res = '0;
        unique case (op_q)
            3'd0:          mdu_res = prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          mdu_res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:    mdu_res = quo_s;
            default:       mdu_res = rem_s;
        endcase
    end

    // Capture op attributes on accept; write the result when it is ready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q   <= '0;
            neg_q  <= 1'b0;
            negr_q <= 1'b0;
            bz_q   <= 1'b0;
            res_q  <= '0;
        end else if (accept) begin
            op_q   <= alu_op_i[2:0];
            neg_q  <= sa ^ sb;
            negr_q <= sa;
            bz_q   <= (rs2_data_i == '0);
            if (!is_m)
                res_q <= base_res;
        end else if (state == S_BUSY && done && !flush_i) begin
            res_q <= mdu_res;
        end
    end

    assign alu_result_o = res_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (accept) state_n = is_m ? S_BUSY : S_DONE;
            S_BUSY:  if (done) state_n = S_DONE;
            S_DONE:  if (ready_i) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (flush_i)
            state_n = S_IDLE;
    end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed self-checking bench for alu_mdu.
// Hand-computed vectors for base ops, M ops, handshake, flush and reset.
module tb_alu_mdu;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [4:0]      alu_op_i = '0;
    logic [XLEN-1:0] rs1_data_i = '0;
    logic [XLEN-1:0] rs2_data_i = '0;
    logic            flush_i = 1'b0;
    logic            valid_o;
    logic            ready_i = 1'b1;
    logic [XLEN-1:0] alu_result_o;

    int n_cmp = 0;
    int n_err = 0;

    alu_mdu #(.XLEN(XLEN)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .alu_op_i     (alu_op_i),
        .rs1_data_i   (rs1_data_i),
        .rs2_data_i   (rs2_data_i),
        .flush_i      (flush_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .alu_result_o (alu_result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an op at the negedge; return #1 after the accept edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        valid_i    = 1'b1;
        alu_op_i   = op;
        rs1_data_i = a;
        rs2_data_i = b;
        @(posedge clk);
        #1;
        valid_i    = 1'b0;
        rs1_data_i = 32'hDEAD_BEEF;
        rs2_data_i = 32'h1234_5678;
    endtask

    task automatic base(input string tag, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
        issue(op, a, b);
        chk({tag, "_valid"}, 64'(valid_o), 64'd1);
        chk(tag, 64'(alu_result_o), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    // Count edges from accept until valid_o, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!valid_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic mop(input string tag, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        int n;
        issue(op, a, b);
        wait_valid(n);
        chk({tag, "_lat"}, 64'(n), 64'd32);
        chk(tag, 64'(alu_result_o), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bit seen;

        #1;
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_result", 64'(alu_result_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;

        // ADD with wrap, plus ready_o timing
        issue(5'b00000, 32'h7FFF_FFFF, 32'h1);
        chk("add_valid", 64'(valid_o), 64'd1);
        chk("add_ready_busy", 64'(ready_o), 64'd0);
        chk("add", 64'(alu_result_o), 64'h8000_0000);
        @(posedge clk);
        #1;
        chk("add_ready_back", 64'(ready_o), 64'd1);
        chk("add_valid_drop", 64'(valid_o), 64'd0);

        base("sra", 5'b01001, 32'h8000_0000, 32'h24, 32'hF800_0000);
        base("sltu", 5'b00011, 32'hFFFF_FFFF, 32'h1, 32'h0);
        base("slt", 5'b00010, 32'hFFFF_FFFF, 32'h1, 32'h1);
        base("sub", 5'b00001, 32'h0, 32'h1, 32'hFFFF_FFFF);
        base("sll", 5'b00111, 32'h1, 32'h3F, 32'h8000_0000);
        base("srl", 5'b01000, 32'h8000_0000, 32'h4, 32'h0800_0000);
        base("xor", 5'b00100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        base("passb", 5'b01010, 32'h1111_1111, 32'hCAFE_F00D, 32'hCAFE_F00D);
        base("illegal", 5'b11111, 32'h5, 32'h6, 32'h0);

        mop("mulh", 5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        mop("mulhu", 5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        mop("mul", 5'b10000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        mop("mulhsu", 5'b10010, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF);
        mop("div0", 5'b10100, 32'd7, 32'd0, 32'hFFFF_FFFF);
        mop("divneg0", 5'b10100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        mop("remu0", 5'b10111, 32'd7, 32'd0, 32'd7);
        mop("divovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        mop("removf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        mop("rem", 5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        mop("div", 5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);

        // DIVU with back-pressure: result held until handshake
        ready_i = 1'b0;
        issue(5'b10101, 32'd100, 32'd7);
        wait_valid(n);
        chk("divu_lat", 64'(n), 64'd32);
        chk("divu", 64'(alu_result_o), 64'd14);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(valid_o), 64'd1);
            chk("hold_result", 64'(alu_result_o), 64'd14);
            chk("hold_ready", 64'(ready_o), 64'd0);
        end
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_valid", 64'(valid_o), 64'd0);
        chk("hs_ready", 64'(ready_o), 64'd1);

        // Flush in cycle T+5 of a MUL
        issue(5'b10000, 32'd9, 32'd9);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_flush_ready", 64'(ready_o), 64'd0);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("flush_ready", 64'(ready_o), 64'd1);
        chk("flush_valid", 64'(valid_o), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (valid_o) seen = 1'b1;
        end
        chk("flush_no_valid", 64'(seen), 64'd0);

        // Flush wins over ready_i in DONE
        issue(5'b00000, 32'd1, 32'd1);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("flushdone_ready", 64'(ready_o), 64'd1);
        chk("flushdone_valid", 64'(valid_o), 64'd0);

        // Async reset mid-divide
        issue(5'b10100, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", 64'(valid_o), 64'd0);
        chk("arst_ready", 64'(ready_o), 64'd1);
        chk("arst_result", 64'(alu_result_o), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1;
            if (valid_o) seen = 1'b1;
        end
        chk("arst_no_valid", 64'(seen), 64'd0);
        base("add_after_rst", 5'b00000, 32'd2, 32'd3, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised multi-cycle execute unit for the RISC-V core: the XLEN-wide integer ALU extended with iterative M-extension multiply/divide. It sits between the decode/register-file read stage and write-back, and uses a valid/ready handshake so a multi-cycle operation can stall the front end. Base ALU ops complete in one cycle. MUL*/DIV*/REM* use a shift-add / restoring-divide datapath that takes XLEN cycles.

## Interface
Parameters:
- XLEN, 32: operand and result width; must be ≥ 8.

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- valid_i  in  1  operands and op are valid this cycle.
- ready_o  out  1  unit can accept an op; high only in IDLE.
- alu_op_i  in  5  operation code; see Operation.
- rs1_data_i  in  XLEN  operand A.
- rs2_data_i  in  XLEN  operand B (register or immediate).
- flush_i  in  1  abort any op in flight; return to IDLE next cycle.
- valid_o  out  1  alu_result_o is valid.
- ready_i  in  1  downstream consumes the result.
- alu_result_o  out  XLEN  result; held stable while valid_o && !ready_i.

## Operation
- Accept condition: `valid_i && ready_o`. On accept, the unit captures the op and both operands; later input changes are ignored.
- Base op codes:
  - 00000 ADD, 00001 SUB, 00010 SLT (signed), 00011 SLTU, 00100 XOR, 00101 AND, 00110 OR.
  - 00111 SLL, 01000 SRL, 01001 SRA. Shift amount is rs2[$clog2(XLEN)-1:0].
  - 01010 PASS_B (result = rs2).
- M op codes: 10000 MUL (low XLEN), 10001 MULH (s×s), 10010 MULHSU (s×u), 10011 MULHU (u×u), 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
- Any other code completes as a base op with result 0.
- SLT/SLTU return zero-extended 0 or 1. All adds, subtracts and shifts wrap modulo 2^XLEN.
- Multiply: unsigned 2·XLEN shift-add over magnitudes, then negate if the sign rule requires it. The high or low half is selected per op.
- Divide: restoring division on magnitudes. Quotient sign is sign(A)^sign(B). Remainder sign is sign(A).
- Divide-by-zero: quotient = all-ones, remainder = A. The op still takes the full XLEN iterations.
- Signed overflow (A = −2^(XLEN−1), B = −1): DIV returns A, REM returns 0.
- FSM:
  - IDLE: on accept of a base op, go to DONE; on accept of an M op, go to BUSY with count = XLEN−1.
  - BUSY: one iteration per cycle. When count = 0, the final correction writes the result and the FSM goes to DONE.
  - DONE: valid_o = 1. When ready_i = 1, go to IDLE.
- flush_i has priority over every transition. The FSM goes to IDLE and valid_o is cleared the next cycle; a result not yet consumed is discarded.

## Timing
- Reset values (async, while rst_ni low): state IDLE, ready_o 1, valid_o 0, alu_result_o 0, counter 0, internal accumulators 0.
- Reset asserted mid-operation aborts the op immediately; no result is produced.
- Base op latency: accepted at cycle T, valid_o = 1 at T+1.
- M op latency: accepted at T, valid_o = 1 at T+XLEN+1 (T+33 for XLEN = 32), independent of operand values.
- ready_o = 0 from the cycle after accept until the cycle after the result handshake. There are no back-to-back accepts, so peak throughput is one op every 2 cycles.
- Result handshake completes on `valid_o && ready_i`. valid_o is 0 the following cycle unless a new op completes.
- The result stays valid for any number of cycles while ready_i = 0.
- valid_i arriving while ready_o = 0 is ignored; upstream holds its inputs.
- flush_i and ready_i high in the same DONE cycle: flush wins, with the same observable effect (IDLE next cycle).

## Structure
- Package alu_pkg holds:
  - the op-code enum alu_op_e (5-bit) and the helper predicate is_mdu_op;
  - the FSM state enum;
  - constants DIV0_QUOT (all-ones) and the per-op signedness bits.
- One sub-module, alu_mdu_iter, holds the multiply/divide iteration datapath: accumulator, shift register and counter, driven by start/done signals.
- The top level holds the FSM, the combinational base ALU, the result register and the handshake.

## Test plan
- ADD 0x7FFFFFFF + 1, ready_i = 1 → valid_o at T+1, result 0x80000000; ready_o back to 1 at T+2.
- SRA 0x80000000 by rs2 = 0x24 (amount 4) → 0xF8000000. SLTU 0xFFFFFFFF, 1 → 0.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0; MULHU of the same → 0xFFFFFFFE; MUL 7 × −3 → 0xFFFFFFEB. Each has valid_o exactly at T+33.
- DIV 7 by 0 → 0xFFFFFFFF; REMU 7 by 0 → 7; DIV 0x80000000 by −1 → 0x80000000; REM −7 by 2 → 0xFFFFFFFF.
- DIVU started, ready_i held 0 for 10 cycles after valid_o → result stable and ready_o = 0 until the handshake; flush_i at cycle T+5 of a second MUL → IDLE at T+6 with no valid_o.
- Assert rst_ni low mid-divide → valid_o = 0 and ready_o = 1 immediately. After release, ADD 2 + 3 → 5 at T+1.
